// File: rtl/xh_chi_link_tx.sv
// CHI link-layer transmit endpoint for a single channel.
// Runs the link activation handshake, transmits flits against receiver-granted
// L-credits and returns every held credit with LCrdReturn flits on teardown.
module xh_chi_link_tx #(
  parameter int unsigned FLIT_W  = 392,
  parameter int unsigned MAX_CRD = 15,
  parameter int unsigned CRD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              link_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              txlinkactivereq,
  input  logic              txlinkactiveack,
  output logic              txflitpend,
  output logic              txflitv,
  output logic [FLIT_W-1:0] txflit,
  input  logic              txlcrdv,
  output logic [CRD_W-1:0]  crd_cnt,
  output logic [1:0]        link_state,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    StStop  = 2'b00,
    StAct   = 2'b01,
    StRun   = 2'b10,
    StDeact = 2'b11
  } state_e;

  localparam logic [CRD_W-1:0] MaxCrd = CRD_W'(MAX_CRD);

  state_e              state_q, state_d;
  logic [CRD_W-1:0]    crd_q, crd_d;
  logic                req_q, req_d;
  logic                flitv_q, flitv_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;
  logic                err_q, err_d;
  logic                send;

  // Accept only while running, enabled and holding at least one credit.
  assign in_ready   = (state_q == StRun) & link_en & (crd_q != '0);
  assign txflitpend = (state_q == StRun) | (state_q == StDeact);

  assign txlinkactivereq = req_q;
  assign txflitv         = flitv_q;
  assign txflit          = flit_q;
  assign crd_cnt         = crd_q;
  assign link_state      = state_q;
  assign proto_err       = err_q;

  // Next-state, credit accounting and transmit-stage decode.
  always_comb begin
    state_d = state_q;
    crd_d   = crd_q;
    err_d   = err_q;
    flit_d  = flit_q;
    send    = 1'b0;

    unique case (state_q)
      StStop: begin
        // Grants are illegal while the link is down.
        if (txlcrdv) err_d = 1'b1;
        if (link_en && !txlinkactiveack) state_d = StAct;
      end
      StAct: begin
        if (txlinkactiveack) state_d = StRun;
      end
      StRun: begin
        if (in_valid && in_ready) begin
          send   = 1'b1;
          flit_d = in_flit;
        end
        if (!link_en) state_d = StDeact;
      end
      StDeact: begin
        // LCrdReturn flit is all-zero.
        if (crd_q != '0) begin
          send   = 1'b1;
          flit_d = '0;
        end
        if (!txlinkactiveack) begin
          state_d = StStop;
          if (crd_q != '0) err_d = 1'b1;
        end
      end
      default: state_d = StStop;
    endcase

    if (state_q != StStop) begin
      if (txlcrdv && !send && (crd_q == MaxCrd)) begin
        err_d = 1'b1;
      end else begin
        crd_d = crd_q + CRD_W'(txlcrdv) - CRD_W'(send);
      end
    end

    // Credits never survive into STOP.
    if (state_d == StStop) crd_d = '0;

    flitv_d = send;
    req_d   = (state_d == StAct) || (state_d == StRun);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StStop;
      crd_q   <= '0;
      req_q   <= 1'b0;
      flitv_q <= 1'b0;
      flit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crd_q   <= crd_d;
      req_q   <= req_d;
      flitv_q <= flitv_d;
      flit_q  <= flit_d;
      err_q   <= err_d;
    end
  end

endmodule
